word36_to_dibit_serializer: RTL and testbench

- Read-side gearbox for 36-bit-wide/2-bit-wide dual-port buffers: accepts 32-bit data words plus 4 byte-parity bits and emits them as sixteen 2-bit symbols (dibits).
- Dibit order matches the 2-bit port address mapping of the dual-ported block RAMs: dibit k of word W is narrow address W*16+k.
- Checks byte parity at word acceptance. Parity is not serialized, because the 2-bit port has no parity lane.
- Sits between a 36-bit RAM read port or word source and a 2-bit consumer.

---
 rtl/word36_to_dibit_serializer.sv | 82 ++++++++
 tb/tb_word36_to_dibit_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/word36_to_dibit_serializer.sv
// word36_to_dibit_serializer: 32-bit word + 4 byte-parity bits in, sixteen 2-bit symbols out.
// Dibit k of a word is data[2k+1:2k]; parity is checked on acceptance and never serialized.
module word36_to_dibit_serializer #(
   parameter bit PAR_ODD   = 1'b0,
   parameter bit PAR_CHECK = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        word_valid,
   output logic        word_ready,
   input  logic [31:0] word_data,
   input  logic [3:0]  word_par,
   output logic        dibit_valid,
   input  logic        dibit_ready,
   output logic [1:0]  dibit_data,
   output logic        dibit_last,
   output logic [3:0]  err_mask,
   output logic [7:0]  err_cnt,
   input  logic        clr_err,
   output logic        busy
);
   logic [31:0] sr_data, hr_data;
   logic        sr_valid, hr_valid, rdy_en;
   logic [3:0]  idx, bad;
   logic        in_xfer, out_xfer, done;

   // rdy_en keeps word_ready low through reset and for the first edge after release
   assign word_ready  = rdy_en & ~hr_valid;
   assign in_xfer     = word_valid & word_ready;
   assign out_xfer    = sr_valid & dibit_ready;
   assign done        = out_xfer & (idx == 4'd15);
   assign dibit_valid = sr_valid;
   assign dibit_data  = sr_data[{idx, 1'b0} +: 2];
   assign dibit_last  = sr_valid & (idx == 4'd15);
   assign busy        = sr_valid | hr_valid;

   for (genvar i = 0; i < 4; i++) begin : g_par
      assign bad[i] = PAR_CHECK & (word_par[i] != ((^word_data[8*i +: 8]) ^ PAR_ODD));
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rdy_en   <= 1'b0;
         sr_valid <= 1'b0;
         sr_data  <= '0;
         idx      <= '0;
         hr_valid <= 1'b0;
         hr_data  <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (done) begin
            // HR takes priority; a full HR implies no input transfer this cycle
            sr_valid <= hr_valid | in_xfer;
            sr_data  <= hr_valid ? hr_data : word_data;
            idx      <= '0;
            hr_valid <= 1'b0;
         end else begin
            if (out_xfer)
               idx <= idx + 4'd1;
            if (in_xfer && !sr_valid) begin
               sr_valid <= 1'b1;
               sr_data  <= word_data;
               idx      <= '0;
            end else if (in_xfer) begin
               hr_valid <= 1'b1;
               hr_data  <= word_data;
            end
         end
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         err_mask <= '0;
         err_cnt  <= '0;
      end else if (in_xfer && |bad) begin
         err_mask <= (clr_err ? 4'h0 : err_mask) | bad;
         err_cnt  <= clr_err ? 8'd1 : (&err_cnt ? err_cnt : err_cnt + 8'd1);
      end else if (clr_err) begin
         err_mask <= '0;
         err_cnt  <= '0;
      end
endmodule

// File: tb/tb_word36_to_dibit_serializer.sv
// tb_word36_to_dibit_serializer: directed stimulus for the 36-to-2 serializer.
// Inputs change on negedge (or #1 after posedge); outputs are sampled on negedge.
module tb_word36_to_dibit_serializer;
   logic        clk = 1'b0, rst_n = 1'b0, word_valid = 1'b0, dibit_ready = 1'b0, clr_err = 1'b0;
   logic [31:0] word_data = '0;
   logic [3:0]  word_par = '0;
   logic        word_ready, dibit_valid, dibit_last, busy;
   logic [1:0]  dibit_data;
   logic [3:0]  err_mask;
   logic [7:0]  err_cnt;
   int          checks = 0, fails = 0;
   logic [1:0]  exp1 [16] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0,
                              2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd3, 2'd1};
   logic [31:0] w3 [3] = '{32'hFFFFFFFF, 32'h00000000, 32'hAAAAAAAA};
   logic [1:0]  ed3 [3] = '{2'd3, 2'd0, 2'd2};

   word36_to_dibit_serializer dut (
      .clk(clk), .rst_n(rst_n), .word_valid(word_valid), .word_ready(word_ready),
      .word_data(word_data), .word_par(word_par), .dibit_valid(dibit_valid),
      .dibit_ready(dibit_ready), .dibit_data(dibit_data), .dibit_last(dibit_last),
      .err_mask(err_mask), .err_cnt(err_cnt), .clr_err(clr_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // sends 32'h76543210 with the given parity and checks its 16 dibits at full rate
   task automatic run_word(input logic [3:0] p);
      @(negedge clk);
      chk("rw_ready", word_ready, 1);
      word_valid = 1'b1; word_data = 32'h76543210; word_par = p; dibit_ready = 1'b1;
      @(negedge clk);
      word_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk("rw_valid", dibit_valid, 1);
         chk("rw_dibit", dibit_data, exp1[k]);
         chk("rw_last", dibit_last, k == 15);
         @(negedge clk);
      end
      chk("rw_busy_end", busy, 0);
      chk("rw_valid_end", dibit_valid, 0);
   endtask

   task automatic drain();
      dibit_ready = 1'b1;
      for (int c = 0; c < 40 && busy; c++) @(negedge clk);
      chk("drain_busy", busy, 0);
   endtask

   initial begin
      int cnt, got, wi, gap, blocked, acc, cyc;
      logic acc_now;
      // reset state
      @(negedge clk);
      chk("rst_ready", word_ready, 0);
      chk("rst_valid", dibit_valid, 0);
      chk("rst_data", dibit_data, 0);
      chk("rst_last", dibit_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mask", err_mask, 0);
      chk("rst_cnt", err_cnt, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", word_ready, 1);

      // single word
      run_word(4'hF);
      chk("single_mask", err_mask, 0);
      chk("single_cnt", err_cnt, 0);

      // backpressure: ready toggles 1,0,1,0
      @(negedge clk);
      word_valid = 1'b1; word_data = 32'h76543210; word_par = 4'hF; dibit_ready = 1'b0;
      @(negedge clk);
      word_valid = 1'b0;
      cnt = 0;
      for (cyc = 0; cnt < 16 && cyc < 64; cyc++) begin
         chk("bp_valid", dibit_valid, 1);
         chk("bp_dibit", dibit_data, exp1[cnt]);
         chk("bp_last", dibit_last, cnt == 15);
         dibit_ready = (cyc % 2 == 0);
         if (dibit_ready) cnt++;
         @(negedge clk);
      end
      chk("bp_count", cnt, 16);
      chk("bp_busy", busy, 0);

      // back-to-back words
      dibit_ready = 1'b1;
      wi = 0; got = 0; gap = 0; blocked = 0;
      word_valid = 1'b1; word_data = w3[0]; word_par = 4'h0;
      for (int c = 0; c < 100 && got < 48; c++) begin
         if (dibit_valid) begin
            chk("b2b_dibit", dibit_data, ed3[got / 16]);
            got++;
         end else if (got > 0) gap++;
         acc_now = word_valid & word_ready;
         if (word_valid && !word_ready) blocked = 1;
         @(posedge clk);
         #1;
         if (acc_now) wi++;
         word_valid = (wi < 3);
         word_data  = (wi < 3) ? w3[wi] : 32'h0;
         @(negedge clk);
      end
      word_valid = 1'b0;
      chk("b2b_count", got, 48);
      chk("b2b_gap", gap, 0);
      chk("b2b_blocked", blocked, 1);
      drain();

      // parity error on byte 0, data unchanged
      run_word(4'hE);
      chk("par_mask", err_mask, 4'h1);
      chk("par_cnt", err_cnt, 1);

      // clear coinciding with a new error on byte 2: new error wins
      @(negedge clk);
      clr_err = 1'b1; word_valid = 1'b1; word_data = 32'h76543210; word_par = 4'hB;
      @(negedge clk);
      clr_err = 1'b0; word_valid = 1'b0;
      chk("clrwin_mask", err_mask, 4'h4);
      chk("clrwin_cnt", err_cnt, 1);
      drain();
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("clr_mask", err_mask, 0);
      chk("clr_cnt", err_cnt, 0);

      // 256 bad words saturate the counter
      acc = 0; cyc = 0;
      word_valid = 1'b1; word_data = 32'h0; word_par = 4'h1;
      while (acc < 256 && cyc < 6000) begin
         acc += int'(word_ready);
         if (acc < 256) begin
            @(negedge clk);
            cyc++;
         end
      end
      @(negedge clk);
      word_valid = 1'b0;
      chk("sat_accepted", acc, 256);
      drain();
      chk("sat_cnt", err_cnt, 255);
      chk("sat_mask", err_mask, 4'h1);

      // reset mid-word with HR full
      @(negedge clk);
      word_valid = 1'b1; word_data = 32'h76543210; word_par = 4'hF;
      @(negedge clk);
      word_data = 32'h0; word_par = 4'h0;
      @(negedge clk);
      word_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_hr_full", word_ready, 0);
      chk("mid_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", dibit_valid, 0);
      chk("mid_rst_data", dibit_data, 0);
      chk("mid_rst_last", dibit_last, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", word_ready, 0);
      chk("mid_rst_cnt", err_cnt, 0);
      chk("mid_rst_mask", err_mask, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_post_ready", word_ready, 1);
      for (int k = 0; k < 4; k++) begin
         chk("mid_no_stale", dibit_valid, 0);
         @(negedge clk);
      end

      // new word accepted in the cycle the last dibit leaves
      word_valid = 1'b1; word_data = 32'h0; word_par = 4'h0; dibit_ready = 1'b1;
      @(negedge clk);
      word_valid = 1'b0;
      for (int c = 0; c < 20 && !dibit_last; c++) @(negedge clk);
      chk("sim_last_seen", dibit_last, 1);
      chk("sim_ready_before", word_ready, 1);
      word_valid = 1'b1; word_data = 32'h00000003;
      @(negedge clk);
      word_valid = 1'b0;
      chk("sim_valid", dibit_valid, 1);
      chk("sim_dibit0", dibit_data, 3);
      chk("sim_last", dibit_last, 0);
      chk("sim_ready", word_ready, 1);
      chk("sim_busy", busy, 1);
      drain();

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
